mem_arbiter: RTL and testbench

- Shares the single memory port (`mem_r_en` / `mem_w_en` / `mem_addr` / `mem_w_data` / `mem_r_data`) between two requesters:
  - port A: the cpu core.
  - port B: the program loader / debug DMA.
- Uses round-robin arbitration with an optional per-port lock for atomic sequences, plus a lock-idle timeout.
- Tracks in-flight reads so each read's data returns only to the port that issued it.
- Sits between the cpu/loader and the memory model.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/rd_tag_pipe.sv | 34 +++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  // Arbiter ownership state; encoding matches the debug owner output.
  typedef enum logic [1:0] {
    StUnlocked = 2'd0,
    StLockA    = 2'd1,
    StLockB    = 2'd2
  } arb_state_t;

  // Requester indices as carried in last_grant and the read tags.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Debug owner encoding.
  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_A    = 2'd1;
  localparam logic [1:0] OWNER_B    = 2'd2;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line of {valid, port} read tags, aligned with the memory read latency.
module rd_tag_pipe #(
  parameter int unsigned Depth = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  input  logic port_i,
  output logic valid_o,
  output logic port_o
);

  logic [Depth-1:0] valid_q;
  logic [Depth-1:0] port_q;

  // Shift tags one stage per cycle; reset drops any in-flight reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      port_q  <= '0;
    end else begin
      valid_q[0] <= valid_i;
      port_q[0]  <= port_i;
      for (int i = 1; i < int'(Depth); i++) begin
        valid_q[i] <= valid_q[i-1];
        port_q[i]  <= port_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign port_o  = port_q[Depth-1];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the cpu (A) and the loader (B),
// with per-port locking, a lock-idle timeout and read-data routing by tag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned ADDR_SIZE    = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic                 a_lock,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [WORD_SIZE-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [WORD_SIZE-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic                 b_lock,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [WORD_SIZE-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [WORD_SIZE-1:0] b_rdata,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_w_data,
  input  logic [WORD_SIZE-1:0] mem_r_data,
  output logic [1:0]           owner
);

  localparam int unsigned    CntW   = $clog2(LOCK_TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(LOCK_TIMEOUT - 1);

  arb_state_t          state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                mem_r_en_q, mem_r_en_d;
  logic                mem_w_en_q, mem_w_en_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_w_data_q, mem_w_data_d;
  logic                issue_port_q, issue_port_d;

  logic                xfer;
  logic                win;
  logic                sel_we;
  logic                sel_lock;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [WORD_SIZE-1:0] sel_wdata;
  logic                tag_valid;
  logic                tag_port;

  // Arbitration state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StUnlocked;
      last_grant_q <= PORT_B;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // Grants and debug owner; gnt never looks at the other port's addr/we.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    owner = OWNER_NONE;
    unique case (state_q)
      StUnlocked: begin
        if (a_req && b_req) begin
          a_gnt = (last_grant_q == PORT_B);
          b_gnt = (last_grant_q == PORT_A);
        end else begin
          a_gnt = a_req;
          b_gnt = b_req;
        end
      end
      StLockA: begin
        a_gnt = a_req;
        owner = OWNER_A;
      end
      StLockB: begin
        b_gnt = b_req;
        owner = OWNER_B;
      end
      default: ;
    endcase
    if (!reset) begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
    end
  end

  // Winner's request fields.
  always_comb begin
    xfer      = a_gnt | b_gnt;
    win       = b_gnt ? PORT_B : PORT_A;
    sel_we    = b_gnt ? b_we : a_we;
    sel_lock  = b_gnt ? b_lock : a_lock;
    sel_addr  = b_gnt ? b_addr : a_addr;
    sel_wdata = b_gnt ? b_wdata : a_wdata;
  end

  // Next arbitration state: transfers set/clear the lock, idle locks age out.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    if (xfer) begin
      last_grant_d = win;
      cnt_d        = '0;
      if (sel_lock) begin
        state_d = (win == PORT_B) ? StLockB : StLockA;
      end else begin
        state_d = StUnlocked;
      end
    end else if (state_q != StUnlocked) begin
      if (cnt_q == CntMax) begin
        state_d = StUnlocked;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Next memory command: one op per accepted transfer, address/data hold when idle.
  always_comb begin
    mem_r_en_d   = xfer & ~sel_we;
    mem_w_en_d   = xfer & sel_we;
    mem_addr_d   = xfer ? sel_addr : mem_addr_q;
    mem_w_data_d = (xfer && sel_we) ? sel_wdata : mem_w_data_q;
    issue_port_d = xfer ? win : issue_port_q;
  end

  // Registered memory command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_w_data_q <= '0;
      issue_port_q <= PORT_A;
    end else begin
      mem_r_en_q   <= mem_r_en_d;
      mem_w_en_q   <= mem_w_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_w_data_q <= mem_w_data_d;
      issue_port_q <= issue_port_d;
    end
  end

  assign mem_r_en   = mem_r_en_q;
  assign mem_w_en   = mem_w_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_w_data = mem_w_data_q;

  // Tags enter when the read strobe is on the memory bus, so they exit with the data.
  rd_tag_pipe #(
    .Depth(READ_LATENCY)
  ) u_rd_tag_pipe (
    .clk_i  (clk),
    .rst_ni (reset),
    .valid_i(mem_r_en_q),
    .port_i (issue_port_q),
    .valid_o(tag_valid),
    .port_o (tag_port)
  );

  // Route returning read data to its issuer.
  always_comb begin
    a_rvalid = tag_valid && (tag_port == PORT_A);
    b_rvalid = tag_valid && (tag_port == PORT_B);
    a_rdata  = mem_r_data;
    b_rdata  = mem_r_data;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table for the steady-state cases plus
// hand-written sequences for lock timeout, mid-read reset and a 3-cycle-latency build.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // DUT 1: READ_LATENCY = 1
  logic        a_req = 0, a_we = 0, a_lock = 0, b_req = 0, b_we = 0, b_lock = 0;
  logic [15:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, m_r_en, m_w_en;
  logic [15:0] a_rdata, b_rdata, m_addr, m_w_data, m_r_data;
  logic [1:0]  owner;

  // DUT 2: READ_LATENCY = 3
  logic        xa_req = 0, xb_req = 0;
  logic [15:0] xa_addr = 0, xb_addr = 0;
  logic        xa_gnt, xb_gnt, xa_rvalid, xb_rvalid, x_r_en, x_w_en;
  logic [15:0] xa_rdata, xb_rdata, x_addr, x_w_data, x_r_data;
  logic [1:0]  x_owner;

  mem_arbiter #(
    .WORD_SIZE(16), .ADDR_SIZE(16), .READ_LATENCY(1), .LOCK_TIMEOUT(16)
  ) u_dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_r_en(m_r_en), .mem_w_en(m_w_en), .mem_addr(m_addr), .mem_w_data(m_w_data),
    .mem_r_data(m_r_data), .owner(owner)
  );

  mem_arbiter #(
    .WORD_SIZE(16), .ADDR_SIZE(16), .READ_LATENCY(3), .LOCK_TIMEOUT(16)
  ) u_dut3 (
    .clk(clk), .reset(reset),
    .a_req(xa_req), .a_we(1'b0), .a_lock(1'b0), .a_addr(xa_addr), .a_wdata(16'h0),
    .a_gnt(xa_gnt), .a_rvalid(xa_rvalid), .a_rdata(xa_rdata),
    .b_req(xb_req), .b_we(1'b0), .b_lock(1'b0), .b_addr(xb_addr), .b_wdata(16'h0),
    .b_gnt(xb_gnt), .b_rvalid(xb_rvalid), .b_rdata(xb_rdata),
    .mem_r_en(x_r_en), .mem_w_en(x_w_en), .mem_addr(x_addr), .mem_w_data(x_w_data),
    .mem_r_data(x_r_data), .owner(x_owner)
  );

  // Memory model: preloaded while reset is low; DUT 1 may write, both read.
  logic [15:0] mem [512];
  logic [15:0] rd1_q, rd3a_q, rd3b_q, rd3c_q;
  always @(posedge clk) begin
    if (!reset) begin
      mem[9'h010] <= 16'hBEEF;
      mem[9'h001] <= 16'h1111;
      mem[9'h002] <= 16'h2222;
    end else begin
      if (m_w_en) mem[m_addr[8:0]] <= m_w_data;
      if (m_r_en) rd1_q <= mem[m_addr[8:0]];
      if (x_r_en) rd3a_q <= mem[x_addr[8:0]];
      rd3b_q <= rd3a_q;
      rd3c_q <= rd3b_q;
    end
  end
  assign m_r_data = rd1_q;
  assign x_r_data = rd3c_q;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        a_req, a_we, a_lock;
    logic [15:0] a_addr, a_wdata;
    logic        b_req, b_we, b_lock;
    logic [15:0] b_addr, b_wdata;
    logic        e_ag, e_bg, e_ren, e_wen;
    logic [15:0] e_addr;
    logic        e_arv, e_brv;
    logic [15:0] e_rdata;
    logic [1:0]  e_owner;
  } vec_t;

  function automatic vec_t mk(
    input logic ar, input logic aw, input logic al, input logic [15:0] aa, input logic [15:0] ad,
    input logic br, input logic bw, input logic bl, input logic [15:0] ba, input logic [15:0] bd,
    input logic ag, input logic bg, input logic ren, input logic wen, input logic [15:0] ea,
    input logic arv, input logic brv, input logic [15:0] erd, input logic [1:0] eo);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_lock = al; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_lock = bl; v.b_addr = ba; v.b_wdata = bd;
    v.e_ag = ag; v.e_bg = bg; v.e_ren = ren; v.e_wen = wen; v.e_addr = ea;
    v.e_arv = arv; v.e_brv = brv; v.e_rdata = erd; v.e_owner = eo;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single read, round-robin stream, locked write/read by B with A waiting.
    vecs[0]  = mk(1,0,0,16'h0010,0, 0,0,0,0,0,           1,0,0,0,0,       0,0,0,0);
    vecs[1]  = mk(0,0,0,0,0,        0,0,0,0,0,           0,0,1,0,16'h0010,0,0,0,0);
    vecs[2]  = mk(0,0,0,0,0,        0,0,0,0,0,           0,0,0,0,0,       1,0,16'hBEEF,0);
    vecs[3]  = mk(0,0,0,0,0,        0,0,0,0,0,           0,0,0,0,0,       0,0,0,0);
    vecs[4]  = mk(1,0,0,16'h0001,0, 1,0,0,16'h0002,0,    0,1,0,0,0,       0,0,0,0);
    vecs[5]  = mk(1,0,0,16'h0001,0, 1,0,0,16'h0002,0,    1,0,1,0,16'h0002,0,0,0,0);
    vecs[6]  = mk(1,0,0,16'h0001,0, 1,0,0,16'h0002,0,    0,1,1,0,16'h0001,0,1,16'h2222,0);
    vecs[7]  = mk(1,0,0,16'h0001,0, 1,0,0,16'h0002,0,    1,0,1,0,16'h0002,1,0,16'h1111,0);
    vecs[8]  = mk(0,0,0,0,0,        0,0,0,0,0,           0,0,1,0,16'h0001,0,1,16'h2222,0);
    vecs[9]  = mk(0,0,0,0,0,        0,0,0,0,0,           0,0,0,0,0,       1,0,16'h1111,0);
    vecs[10] = mk(0,0,0,0,0,        0,0,0,0,0,           0,0,0,0,0,       0,0,0,0);
    vecs[11] = mk(1,0,0,16'h0010,0, 1,1,1,16'h0100,16'h1234, 0,1,0,0,0,   0,0,0,0);
    vecs[12] = mk(1,0,0,16'h0010,0, 1,0,0,16'h0100,0,    0,1,0,1,16'h0100,0,0,0,2);
    vecs[13] = mk(1,0,0,16'h0010,0, 0,0,0,0,0,           1,0,1,0,16'h0100,0,0,0,0);
    vecs[14] = mk(0,0,0,0,0,        0,0,0,0,0,           0,0,1,0,16'h0010,0,1,16'h1234,0);
    vecs[15] = mk(0,0,0,0,0,        0,0,0,0,0,           0,0,0,0,0,       1,0,16'hBEEF,0);

    // Reset state, with a pending request to show gnt is gated.
    a_req = 1; a_addr = 16'h0010;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_a_gnt", {15'h0, a_gnt}, 16'h0);
    chk("rst_r_en", {15'h0, m_r_en}, 16'h0);
    chk("rst_w_en", {15'h0, m_w_en}, 16'h0);
    chk("rst_addr", m_addr, 16'h0);
    chk("rst_owner", {14'h0, owner}, 16'h0);
    a_req = 0;
    @(negedge clk);
    reset = 1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_lock = vecs[i].a_lock;
      a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
      b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_lock = vecs[i].b_lock;
      b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
      #1;
      chk($sformatf("v%0d a_gnt", i), {15'h0, a_gnt}, {15'h0, vecs[i].e_ag});
      chk($sformatf("v%0d b_gnt", i), {15'h0, b_gnt}, {15'h0, vecs[i].e_bg});
      chk($sformatf("v%0d r_en", i), {15'h0, m_r_en}, {15'h0, vecs[i].e_ren});
      chk($sformatf("v%0d w_en", i), {15'h0, m_w_en}, {15'h0, vecs[i].e_wen});
      chk($sformatf("v%0d a_rvalid", i), {15'h0, a_rvalid}, {15'h0, vecs[i].e_arv});
      chk($sformatf("v%0d b_rvalid", i), {15'h0, b_rvalid}, {15'h0, vecs[i].e_brv});
      chk($sformatf("v%0d owner", i), {14'h0, owner}, {14'h0, vecs[i].e_owner});
      if (vecs[i].e_ren || vecs[i].e_wen)
        chk($sformatf("v%0d mem_addr", i), m_addr, vecs[i].e_addr);
      if (vecs[i].e_wen)
        chk($sformatf("v%0d mem_w_data", i), m_w_data, 16'h1234);
      if (vecs[i].e_arv) chk($sformatf("v%0d a_rdata", i), a_rdata, vecs[i].e_rdata);
      if (vecs[i].e_brv) chk($sformatf("v%0d b_rdata", i), b_rdata, vecs[i].e_rdata);
    end

    // Lock timeout: A locks and goes quiet; B waits out LOCK_TIMEOUT cycles.
    @(negedge clk);
    a_req = 1; a_we = 0; a_lock = 1; a_addr = 16'h0010;
    b_req = 0; b_we = 0; b_lock = 0;
    #1 chk("lock_a_gnt", {15'h0, a_gnt}, 16'h1);
    @(negedge clk);
    a_req = 0; a_lock = 0;
    b_req = 1; b_addr = 16'h0002;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      chk($sformatf("to%0d b_gnt", k), {15'h0, b_gnt}, 16'h0);
      chk($sformatf("to%0d owner", k), {14'h0, owner}, 16'h1);
    end
    @(negedge clk);
    #1;
    chk("to17 b_gnt", {15'h0, b_gnt}, 16'h1);
    chk("to17 owner", {14'h0, owner}, 16'h0);
    @(negedge clk);
    b_req = 0;
    repeat (2) @(negedge clk);

    // Reset one cycle after a read accept discards it.
    a_req = 1; a_addr = 16'h0010;
    #1 chk("rr a_gnt", {15'h0, a_gnt}, 16'h1);
    @(negedge clk);
    a_req = 0;
    #1 chk("rr r_en_before", {15'h0, m_r_en}, 16'h1);
    #2 reset = 0;
    a_req = 1;
    #1;
    chk("rr r_en_async", {15'h0, m_r_en}, 16'h0);
    chk("rr a_gnt_gated", {15'h0, a_gnt}, 16'h0);
    chk("rr addr_clr", m_addr, 16'h0);
    a_req = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d a_rvalid", k), {15'h0, a_rvalid}, 16'h0);
      chk($sformatf("rr%0d b_rvalid", k), {15'h0, b_rvalid}, 16'h0);
    end

    // READ_LATENCY=3: back-to-back A,B,A reads, data 4 cycles after each accept.
    for (int c = 0; c < 8; c++) begin
      logic        eag, ebg, earv, ebrv;
      logic [15:0] erd;
      @(negedge clk);
      xa_req = (c < 3);
      xb_req = (c < 3);
      xa_addr = (c == 0) ? 16'h0001 : 16'h0010;
      xb_addr = 16'h0002;
      eag  = (c == 0) || (c == 2);
      ebg  = (c == 1);
      earv = (c == 4) || (c == 6);
      ebrv = (c == 5);
      erd  = (c == 4) ? 16'h1111 : (c == 5) ? 16'h2222 : 16'hBEEF;
      #1;
      chk($sformatf("l3c%0d a_gnt", c), {15'h0, xa_gnt}, {15'h0, eag});
      chk($sformatf("l3c%0d b_gnt", c), {15'h0, xb_gnt}, {15'h0, ebg});
      chk($sformatf("l3c%0d a_rvalid", c), {15'h0, xa_rvalid}, {15'h0, earv});
      chk($sformatf("l3c%0d b_rvalid", c), {15'h0, xb_rvalid}, {15'h0, ebrv});
      if (earv) chk($sformatf("l3c%0d a_rdata", c), xa_rdata, erd);
      if (ebrv) chk($sformatf("l3c%0d b_rdata", c), xb_rdata, erd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
